// File: rtl/dff_scan_pkg.sv
// Shared types and constants for the scan-chain load/capture/unload controller.
package dff_scan_pkg;

  localparam int CHAIN_LEN_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

endpackage

// File: rtl/dff_scan_cnt.sv
// Clearable up-counter.
// tc flags the last bit position of the chain (count == N-1).
module dff_scan_cnt #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en)    count <= count + W'(1);
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/dff_scan_ctrl.sv
// Drives a serial D-flop chain through load, capture and unload, and checks q/qbar.
// Optional DFF_SCAN_COMPARE_EN adds an expected-value input and a mismatch flag.
module dff_scan_ctrl
  import dff_scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
`ifdef DFF_SCAN_COMPARE_EN
  input  logic [CHAIN_LEN-1:0] expected,
  output logic                 mismatch,
`endif
  input  logic                 q,
  input  logic                 qbar,
  output logic                 d,
  output logic                 shift_en,
  output logic                 capture,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result,
  output logic                 err
);

  localparam int W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  state_t               state;
  logic [CHAIN_LEN-1:0] pat_lat;
  logic [CHAIN_LEN-1:0] res_sr;
  logic [CHAIN_LEN-1:0] nxt_res;
  logic [W-1:0]         cnt;
  logic                 tc;
  logic                 run;
  logic                 cnt_clr;
`ifdef DFF_SCAN_COMPARE_EN
  logic [CHAIN_LEN-1:0] exp_lat;
`endif

  // Counter returns to 0 on every exit from a shifting state.
  always_comb begin
    run     = (state == SHIFT_IN) || (state == SHIFT_OUT);
    cnt_clr = !run || tc || abort;
  end

  dff_scan_cnt #(.N(CHAIN_LEN), .W(W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (run),
    .count (cnt),
    .tc    (tc)
  );

  // First sample lands in bit 0 once all CHAIN_LEN samples have shifted down.
  assign nxt_res = {q, res_sr[CHAIN_LEN-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      d        <= 1'b0;
      shift_en <= 1'b0;
      capture  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      pat_lat  <= '0;
      res_sr   <= '0;
`ifdef DFF_SCAN_COMPARE_EN
      exp_lat  <= '0;
      mismatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            pat_lat  <= pattern_in;
`ifdef DFF_SCAN_COMPARE_EN
            exp_lat  <= expected;
`endif
            d        <= pattern_in[0];
            shift_en <= 1'b1;
            busy     <= 1'b1;
            err      <= 1'b0;
            state    <= SHIFT_IN;
          end
        end
        SHIFT_IN: begin
          if (abort) begin
            state    <= IDLE;
            d        <= 1'b0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
          end else if (tc) begin
            state    <= CAPTURE;
            d        <= 1'b0;
            shift_en <= 1'b0;
            capture  <= 1'b1;
          end else begin
            d <= pat_lat[cnt + W'(1)];
          end
        end
        CAPTURE: begin
          capture <= 1'b0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= SHIFT_OUT;
            shift_en <= 1'b1;
          end
        end
        SHIFT_OUT: begin
          if (q == qbar) err <= 1'b1;
          res_sr <= nxt_res;
          if (abort) begin
            state    <= IDLE;
            shift_en <= 1'b0;
            busy     <= 1'b0;
          end else if (tc) begin
            state    <= DONE;
            shift_en <= 1'b0;
            done     <= 1'b1;
            result   <= nxt_res;
`ifdef DFF_SCAN_COMPARE_EN
            mismatch <= (nxt_res != exp_lat);
`endif
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          d        <= 1'b0;
          shift_en <= 1'b0;
          capture  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_scan_ctrl.sv
// Directed bench for dff_scan_ctrl driving an 8-flop behavioural chain.
// Build with DFF_SCAN_COMPARE_EN to also exercise the compare option.
module tb_dff_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] pattern_in;
  logic       q, qbar, d, shift_en, capture, busy, done, err;
  logic [7:0] result;
`ifdef DFF_SCAN_COMPARE_EN
  logic [7:0] expected;
  logic       mismatch;
`endif

  logic [7:0] chain = '0;
  logic       qforce = 1'b0;
  logic       stuck = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic tr_d [0:63];
  logic tr_se[0:63];
  logic tr_cp[0:63];

  always #5 clk = ~clk;

  dff_scan_ctrl #(.CHAIN_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern_in(pattern_in),
`ifdef DFF_SCAN_COMPARE_EN
    .expected(expected), .mismatch(mismatch),
`endif
    .q(q), .qbar(qbar), .d(d), .shift_en(shift_en), .capture(capture),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  // Ideal chain; capture holds state, except the optional stuck flop that
  // holds pattern bit 0 after load.
  always @(posedge clk) begin
    if (shift_en)             chain <= {chain[6:0], d};
    else if (capture && stuck) chain[7] <= 1'b0;
  end
  assign q    = chain[7];
  assign qbar = qforce ? q : ~q;

  // Starts a sequence and tracks it cycle by cycle; hooks fire at the given cycle.
  task automatic run(input logic [7:0] pat, input int start_at, input int abort_at,
                     input int rst_at, input int eq_at,
                     output int nbusy, output int ndone, output int done_cyc, output bit tmo);
    nbusy = 0; ndone = 0; done_cyc = 0; tmo = 1'b1;
    @(negedge clk);
    pattern_in = pat; start = 1'b1;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; rst = 1'b0; qforce = 1'b0;
      pattern_in = ~pat;
      tr_d[c] = d; tr_se[c] = shift_en; tr_cp[c] = capture;
      if (!busy) begin tmo = 1'b0; break; end
      nbusy++;
      if (done) begin ndone++; done_cyc = c; end
      if (c == start_at) start = 1'b1;
      if (c == abort_at) abort = 1'b1;
      if (c == rst_at)   rst = 1'b1;
      if (c == eq_at)    qforce = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern_in = '0;
`ifdef DFF_SCAN_COMPARE_EN
    expected = '0;
`endif
    repeat (2) @(negedge clk);
    n_chk++;
    if ({d, shift_en, capture, busy, done, err} !== 6'b0 || result !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctl=%b result=%h, want ctl=000000 result=00",
               {d, shift_en, capture, busy, done, err}, result);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int nb, nd, dc; bit tmo;
    logic [7:0] pat = 8'hA5;
`ifdef DFF_SCAN_COMPARE_EN
    expected = 8'hA5;
`endif
    run(pat, 0, 0, 0, 0, nb, nd, dc, tmo);
    n_chk++;
    if (tmo || nb != 18 || nd != 1 || dc != 18) begin
      n_fail++;
      $display("FAIL basic_timing: got tmo=%0d busy=%0d done=%0d at %0d, want 0/18/1/18",
               tmo, nb, nd, dc);
    end
    for (int c = 1; c <= 8; c++) begin
      n_chk++;
      if (tr_se[c] !== 1'b1 || tr_d[c] !== pat[c-1] || tr_cp[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL shift_in_cyc%0d: got se=%b d=%b cap=%b, want se=1 d=%b cap=0",
                 c, tr_se[c], tr_d[c], tr_cp[c], pat[c-1]);
      end
    end
    n_chk++;
    if (tr_se[9] !== 1'b0 || tr_d[9] !== 1'b0 || tr_cp[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_cyc: got se=%b d=%b cap=%b, want 0 0 1", tr_se[9], tr_d[9], tr_cp[9]);
    end
    for (int c = 10; c <= 17; c++) begin
      n_chk++;
      if (tr_se[c] !== 1'b1 || tr_d[c] !== 1'b0 || tr_cp[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL shift_out_cyc%0d: got se=%b d=%b cap=%b, want 1 0 0",
                 c, tr_se[c], tr_d[c], tr_cp[c]);
      end
    end
    n_chk++;
    if (result !== 8'hA5 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got result=%h err=%b, want a5 0", result, err);
    end
`ifdef DFF_SCAN_COMPARE_EN
    n_chk++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_mismatch: got %b, want 0", mismatch);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int nb, nd, dc; bit tmo;
    run(8'h3C, 4, 0, 0, 0, nb, nd, dc, tmo);
    n_chk++;
    if (tmo || nb != 18 || nd != 1 || result !== 8'h3C) begin
      n_fail++;
      $display("FAIL start_ignored: got tmo=%0d busy=%0d done=%0d result=%h, want 0/18/1/3c",
               tmo, nb, nd, result);
    end
  endtask

  task automatic test_abort();
    int nb, nd, dc; bit tmo;
    run(8'h55, 0, 13, 0, 0, nb, nd, dc, tmo);
    n_chk++;
    if (tmo || nb != 13 || nd != 0 || result !== 8'h3C) begin
      n_fail++;
      $display("FAIL abort_shift_out: got tmo=%0d busy=%0d done=%0d result=%h, want 0/13/0/3c",
               tmo, nb, nd, result);
    end
    // start with abort in IDLE: abort wins
    start = 1'b1; abort = 1'b1; pattern_in = 8'hFF;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || shift_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_start_abort: got busy=%b se=%b, want 0 0", busy, shift_en);
    end
    // abort during DONE is ignored
    run(8'h96, 0, 18, 0, 0, nb, nd, dc, tmo);
    n_chk++;
    if (tmo || nb != 18 || nd != 1 || dc != 18 || result !== 8'h96) begin
      n_fail++;
      $display("FAIL abort_in_done: got tmo=%0d busy=%0d done=%0d at %0d result=%h, want 0/18/1/18/96",
               tmo, nb, nd, dc, result);
    end
  endtask

  task automatic test_err();
    int nb, nd, dc; bit tmo;
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pre: got %b, want 0", err);
    end
    run(8'hF0, 0, 0, 0, 12, nb, nd, dc, tmo);
    n_chk++;
    if (tmo || nd != 1 || err !== 1'b1 || result !== 8'hF0) begin
      n_fail++;
      $display("FAIL err_set: got tmo=%0d done=%0d err=%b result=%h, want 0/1/1/f0",
               tmo, nd, err, result);
    end
    run(8'h81, 0, 0, 0, 0, nb, nd, dc, tmo);
    n_chk++;
    if (tmo || nd != 1 || err !== 1'b0 || result !== 8'h81) begin
      n_fail++;
      $display("FAIL err_clear: got tmo=%0d done=%0d err=%b result=%h, want 0/1/0/81",
               tmo, nd, err, result);
    end
  endtask

  task automatic test_rst_mid();
    int nb, nd, dc; bit tmo;
    run(8'h77, 0, 0, 5, 0, nb, nd, dc, tmo);
    n_chk++;
    if (tmo || nb != 5 || nd != 0) begin
      n_fail++;
      $display("FAIL rst_mid_len: got tmo=%0d busy=%0d done=%0d, want 0/5/0", tmo, nb, nd);
    end
    n_chk++;
    if ({d, shift_en, capture, busy, done, err} !== 6'b0 || result !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got ctl=%b result=%h, want 000000 00",
               {d, shift_en, capture, busy, done, err}, result);
    end
    run(8'h5A, 0, 0, 0, 0, nb, nd, dc, tmo);
    n_chk++;
    if (tmo || nb != 18 || nd != 1 || result !== 8'h5A) begin
      n_fail++;
      $display("FAIL rst_recover: got tmo=%0d busy=%0d done=%0d result=%h, want 0/18/1/5a",
               tmo, nb, nd, result);
    end
  endtask

`ifdef DFF_SCAN_COMPARE_EN
  task automatic test_compare();
    int nb, nd, dc; bit tmo;
    expected = 8'hA5; stuck = 1'b1;
    run(8'hA5, 0, 0, 0, 0, nb, nd, dc, tmo);
    stuck = 1'b0;
    n_chk++;
    if (tmo || nd != 1 || result !== 8'hA4 || mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL compare_stuck: got tmo=%0d done=%0d result=%h mismatch=%b, want 0/1/a4/1",
               tmo, nd, result, mismatch);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_abort();
    test_err();
    test_rst_mid();
`ifdef DFF_SCAN_COMPARE_EN
    test_compare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
